fan_tach_meter: RTL and testbench

- Measurement counterpart of the time-base generators: it consumes the existing 1 us and 1 s tick pulses and an external fan tachometer signal.
- Produces the tach period in microseconds, pulses per second, RPM, and a stall flag.
- Sits between the fan tach input pin and the display and PWM-control logic.

---
 rtl/fan_tach_meter_pkg.sv | 25 ++
 rtl/fan_tach_meter_tach_sync_edge.sv | 31 +++
 rtl/fan_tach_meter.sv | 129 ++++++++++++
 tb/tb_fan_tach_meter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_tach_meter_pkg.sv
// rtl/fan_tach_meter_pkg.sv - shared types, defaults and RPM helper for the fan tach meter
package fan_tach_meter_pkg;

    typedef enum logic {
        TACH_IDLE  = 1'b0,
        TACH_ARMED = 1'b1
    } tach_state_e;

    localparam int DEFAULT_TIMEOUT_US = 500000;
    localparam int RPM_W              = 16;

    // pulses/s * 60 / ppr via shifts and adds; anything wider than RPM_W clamps
    function automatic logic [RPM_W-1:0] rpm_from_pps(input logic [23:0] pps, input int ppr);
        logic [31:0] w;
        logic [31:0] r;
        w = {8'd0, pps};
        case (ppr)
            1:       r = (w << 6) - (w << 2);
            4:       r = (w << 4) - w;
            default: r = (w << 5) - (w << 1);
        endcase
        return (r > 32'h0000_FFFF) ? 16'hFFFF : r[RPM_W-1:0];
    endfunction

endpackage

// File: rtl/fan_tach_meter_tach_sync_edge.sv
// rtl/fan_tach_meter_tach_sync_edge.sv - 2-flop synchronizer plus registered falling-edge pulse
module tach_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic fall
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic fall_q;

    // prev_q resets to 0, so a pin already high after reset never fakes an edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fall_q  <= prev_q & ~sync2_q;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/fan_tach_meter.sv
// rtl/fan_tach_meter.sv - tach period, pulses per second, RPM and stall detection
module fan_tach_meter
    import fan_tach_meter_pkg::*;
#(
    parameter int PERIOD_W   = 20,
    parameter int TIMEOUT_US = DEFAULT_TIMEOUT_US,
    parameter int PPR        = 2,
    parameter int EDGE_W     = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_usec,
    input  logic                clk_sec,
    input  logic                tach_in,
    output logic [PERIOD_W-1:0] period_us,
    output logic                period_valid,
    output logic [EDGE_W-1:0]   pulses_per_sec,
    output logic [RPM_W-1:0]    rpm,
    output logic                rpm_valid,
    output logic                stall
);

    localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT_US);
    localparam logic [EDGE_W-1:0]   EDGE_MAX    = '1;

    tach_state_e         state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                stall_q, stall_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [EDGE_W-1:0]   pps_q, pps_d;
    logic [RPM_W-1:0]    rpm_q, rpm_d;
    logic                rpm_valid_q, rpm_valid_d;

    logic                fall;
    logic [PERIOD_W-1:0] usec_inc;
    logic [EDGE_W-1:0]   edge_sum;

    tach_sync_edge u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (tach_in),
        .fall     (fall)
    );

    assign usec_inc = {{(PERIOD_W-1){1'b0}}, clk_usec};
    assign edge_sum = (fall && edge_cnt_q != EDGE_MAX) ? edge_cnt_q + 1'b1 : edge_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= TACH_IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stall_q        <= 1'b0;
            edge_cnt_q     <= '0;
            pps_q          <= '0;
            rpm_q          <= '0;
            rpm_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stall_q        <= stall_d;
            edge_cnt_q     <= edge_cnt_d;
            pps_q          <= pps_d;
            rpm_q          <= rpm_d;
            rpm_valid_q    <= rpm_valid_d;
        end
    end

    // an edge arriving on the timeout cycle takes precedence over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            TACH_IDLE:  if (fall) state_d = TACH_ARMED;
            TACH_ARMED: if (!fall && cnt_q == TIMEOUT_CNT) state_d = TACH_IDLE;
            default:    state_d = TACH_IDLE;
        endcase
    end

    always_comb begin
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        stall_d        = stall_q;
        edge_cnt_d     = edge_sum;
        pps_d          = pps_q;
        rpm_d          = rpm_q;
        rpm_valid_d    = 1'b0;

        case (state_q)
            TACH_IDLE: begin
                if (fall) cnt_d = '0;
            end
            TACH_ARMED: begin
                if (fall) begin
                    period_d       = cnt_q + usec_inc;
                    period_valid_d = 1'b1;
                    stall_d        = 1'b0;
                    cnt_d          = '0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    stall_d  = 1'b1;
                    period_d = '0;
                end else begin
                    cnt_d = cnt_q + usec_inc;
                end
            end
            default: ;
        endcase

        if (clk_sec) begin
            pps_d       = edge_sum;
            edge_cnt_d  = '0;
            rpm_d       = rpm_from_pps(24'(edge_sum), PPR);
            rpm_valid_d = 1'b1;
        end
    end

    assign period_us      = period_q;
    assign period_valid   = period_valid_q;
    assign stall          = stall_q;
    assign pulses_per_sec = pps_q;
    assign rpm            = rpm_q;
    assign rpm_valid      = rpm_valid_q;

endmodule

// File: tb/tb_fan_tach_meter.sv
// tb/tb_fan_tach_meter.sv - scoreboard bench for fan_tach_meter
module tb_fan_tach_meter;

    localparam int PW   = 20;
    localparam int TO   = 5000;
    localparam int PPR  = 2;
    localparam int EW   = 10;
    localparam int EMAX = 1023;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_usec;
    logic          clk_sec;
    logic          tach_in;
    logic [PW-1:0] period_us;
    logic          period_valid;
    logic [EW-1:0] pulses_per_sec;
    logic [15:0]   rpm;
    logic          rpm_valid;
    logic          stall;

    always #5 clk = ~clk;

    fan_tach_meter #(.PERIOD_W(PW), .TIMEOUT_US(TO), .PPR(PPR), .EDGE_W(EW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk_usec       (clk_usec),
        .clk_sec        (clk_sec),
        .tach_in        (tach_in),
        .period_us      (period_us),
        .period_valid   (period_valid),
        .pulses_per_sec (pulses_per_sec),
        .rpm            (rpm),
        .rpm_valid      (rpm_valid),
        .stall          (stall)
    );

    typedef struct { int e; int v; } per_t;
    typedef struct { int e; int p; int r; } rpm_t;
    typedef struct { int e; bit lvl; } stl_t;

    per_t pq[$];
    rpm_t rq[$];
    stl_t sq[$];

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int last_e = 0;
    int auto_sec = 0;

    // reference state: edge times, tick counts and window totals
    int pend[$];
    bit have_prev = 0;
    bit prev_t = 0;
    bit m_armed = 0;
    bit m_stall = 0;
    int m_elapsed = 0;
    int m_win = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model(input int e, input bit t, input bit s, input bit u, input bit r_n);
        bit fall;
        int v;
        if (!r_n) begin
            pend.delete();
            if (m_stall) sq.push_back('{e, 1'b0});
            m_stall   = 0;
            m_armed   = 0;
            m_win     = 0;
            have_prev = 0;
            return;
        end
        // a high-to-low change between two samples becomes visible to the meter 3 edges later
        if (have_prev && prev_t && !t) pend.push_back(e + 3);
        prev_t    = t;
        have_prev = 1;
        fall = (pend.size() > 0 && pend[0] == e);
        if (fall) void'(pend.pop_front());

        if (m_armed) begin
            if (fall) begin
                pq.push_back('{e, m_elapsed + int'(u)});
                if (m_stall) sq.push_back('{e, 1'b0});
                m_stall   = 0;
                m_elapsed = 0;
            end else if (m_elapsed == TO) begin
                if (!m_stall) sq.push_back('{e, 1'b1});
                m_stall = 1;
                m_armed = 0;
            end else begin
                m_elapsed += int'(u);
            end
        end else if (fall) begin
            m_armed   = 1;
            m_elapsed = 0;
        end

        if (s) begin
            v = m_win + int'(fall);
            if (v > EMAX) v = EMAX;
            rq.push_back('{e, v, (v * 60 / PPR > 65535) ? 65535 : v * 60 / PPR});
            m_win = 0;
        end else if (fall && m_win < EMAX) begin
            m_win++;
        end
    endtask

    task automatic step(input bit t, input bit s, input bit r_n);
        int e;
        bit u;
        bit se;
        @(negedge clk);
        e  = edge_no + 1;
        u  = (e % 2 == 0);
        se = s || (auto_sec > 0 && e % auto_sec == 0);
        tach_in  = t;
        clk_sec  = se;
        clk_usec = u;
        reset_n  = r_n;
        last_e   = e;
        model(e, t, se, u, r_n);
    endtask

    task automatic cyc(input int low, input int high);
        repeat (low) step(1'b0, 1'b0, 1'b1);
        repeat (high) step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b1);
    endtask

    // next falling sample lands its edge on an edge of the given parity (even edges carry clk_usec)
    task automatic align(input int par);
        while ((last_e + 4) % 2 != par) step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period_us"}, int'(period_us), 0);
        chk({tag, "_period_valid"}, int'(period_valid), 0);
        chk({tag, "_pps"}, int'(pulses_per_sec), 0);
        chk({tag, "_rpm"}, int'(rpm), 0);
        chk({tag, "_rpm_valid"}, int'(rpm_valid), 0);
        chk({tag, "_stall"}, int'(stall), 0);
    endtask

    bit stall_prev = 0;
    per_t xp;
    rpm_t xr;
    stl_t xs;

    always @(negedge clk) begin
        if (period_valid) begin
            if (pq.size() == 0) chk("period_valid_unexpected", edge_no, -1);
            else begin
                xp = pq.pop_front();
                chk("period_edge", edge_no, xp.e);
                chk("period_us", int'(period_us), xp.v);
            end
        end
        if (rpm_valid) begin
            if (rq.size() == 0) chk("rpm_valid_unexpected", edge_no, -1);
            else begin
                xr = rq.pop_front();
                chk("rpm_edge", edge_no, xr.e);
                chk("pulses_per_sec", int'(pulses_per_sec), xr.p);
                chk("rpm", int'(rpm), xr.r);
            end
        end
        if (stall != stall_prev) begin
            if (sq.size() == 0) chk("stall_change_unexpected", edge_no, -1);
            else begin
                xs = sq.pop_front();
                chk("stall_edge", edge_no, xs.e);
                chk("stall_level", int'(stall), int'(xs.lvl));
                if (stall) chk("stall_period_zero", int'(period_us), 0);
            end
        end
        stall_prev = stall;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        tach_in  = 1'b1;
        clk_usec = 1'b0;
        clk_sec  = 1'b0;

        for (int i = 0; i < 4; i++) step(bit'(i % 2), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_all_zero("reset");
        idle(8);

        // 1000 us square wave; first edge only arms
        repeat (4) cyc(1000, 1000);
        chk("wave_period_us", int'(period_us), 1000);
        chk("wave_stall", int'(stall), 0);

        // closing edge coincides with a usec tick
        align(1);
        cyc(100, 101);
        cyc(100, 20);
        idle(5);
        chk("tick_on_fall_period", int'(period_us), 101);

        step(1'b1, 1'b1, 1'b1);
        repeat (50) cyc(20, 20);
        idle(6);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("win50_pps", int'(pulses_per_sec), 50);
        chk("win50_rpm", int'(rpm), 1500);

        repeat (1100) cyc(2, 2);
        idle(6);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("win1100_pps", int'(pulses_per_sec), 1023);
        chk("win1100_rpm", int'(rpm), 30690);

        // fourth edge lands on the clk_sec cycle
        repeat (3) cyc(5, 5);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("sec_fall_pps", int'(pulses_per_sec), 4);
        idle(20);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("next_window_pps", int'(pulses_per_sec), 0);

        cyc(5, 5);
        idle(12000);
        chk("stall_set", int'(stall), 1);
        chk("stall_period_us", int'(period_us), 0);
        cyc(10, 3990);
        chk("stall_after_one_edge", int'(stall), 1);
        cyc(10, 100);
        chk("stall_cleared", int'(stall), 0);
        chk("stall_recover_period", int'(period_us), 2000);

        // edge on the exact timeout cycle measures instead of stalling
        align(0);
        cyc(10, 2 * TO + 1 - 10);
        cyc(10, 50);
        chk("timeout_tie_stall", int'(stall), 0);
        chk("timeout_tie_period", int'(period_us), TO);

        cyc(10, 10);
        while (m_elapsed < 700) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_all_zero("midreset");
        cyc(10, 1990);
        cyc(10, 1990);
        chk("midreset_period", int'(period_us), 1000);

        auto_sec = 1777;
        repeat (40) cyc(int'($urandom_range(1, 150)), int'($urandom_range(1, 300)));
        idle(20);
        auto_sec = 0;
        idle(10);

        chk("period_queue_drained", pq.size(), 0);
        chk("rpm_queue_drained", rq.size(), 0);
        chk("stall_queue_drained", sq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
